// File: rtl/video_tpg_pkg.sv
// video_tpg_pkg: shared constants for the video test-pattern generator.
//   - Pattern mode encodings (3-bit mode field).
//   - Colour-bar table as 3-bit {R,G,B} on/off masks; each bit is expanded
//     to a full COLOR_W component (all-ones or zero) by the consumer.
package video_tpg_pkg;

  localparam logic [2:0] MODE_SOLID = 3'd0;
  localparam logic [2:0] MODE_BARS  = 3'd1;
  localparam logic [2:0] MODE_RAMP  = 3'd2;
  localparam logic [2:0] MODE_CHECK = 3'd3;
  localparam logic [2:0] MODE_MBAR  = 3'd4;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red,
  // blue, black. Packed with index 7 on the left of the literal.
  localparam logic [7:0][2:0] BAR_MASK = {
    3'b000,  // 7 black
    3'b001,  // 6 blue
    3'b100,  // 5 red
    3'b101,  // 4 magenta
    3'b010,  // 3 green
    3'b011,  // 2 cyan
    3'b110,  // 1 yellow
    3'b111   // 0 white
  };

endpackage

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters and region decode for a progressive frame.
//   CLK, RSTn (sync, active-low), en (low holds counters at 0,0)
//   h, v        : current pixel / line counters
//   de          : inside active area
//   hs, vs      : inside sync region (active-high here; polarity applied by
//                 the consumer)
//   last_pixel  : current position is the final pixel of the frame
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          en,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          de,
  output logic          hs,
  output logic          vs,
  output logic          last_pixel
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  // Region bounds kept 32-bit so an end bound equal to the total still fits.
  localparam logic [31:0] H_ACT  = 32'(H_ACTIVE);
  localparam logic [31:0] HS_BEG = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] V_ACT  = 32'(V_ACTIVE);
  localparam logic [31:0] VS_BEG = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END = 32'(V_ACTIVE + V_FP + V_SYNC);

  logic [31:0] h32, v32;
  logic        h_last;

  assign h32        = 32'(h);
  assign v32        = 32'(v);
  assign h_last     = (h == H_LAST);
  assign last_pixel = h_last && (v == V_LAST);

  always_ff @(posedge CLK) begin
    if (!RSTn || !en) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  assign de = (h32 < H_ACT) && (v32 < V_ACT);
  assign hs = (h32 >= HS_BEG) && (h32 < HS_END);
  // Whole lines, aligned to h = 0: no half-line offset.
  assign vs = (v32 >= VS_BEG) && (v32 < VS_END);

endmodule

// File: rtl/video_tpg.sv
// video_tpg: video timing + memory-free test-pattern source.
//   CLK, RSTn (sync, active-low), en (low holds everything at reset values)
//   mode       : pattern select, latched only on the last pixel of a frame
//   solid_rgb  : {R,G,B} for solid mode and the moving-bar background
//   vid_data   : {R,G,B} pixel, zero outside active video
//   vid_de/hs/vs, frame_start : all registered in the same stage as vid_data
module video_tpg
  import video_tpg_pkg::*;
#(
  parameter int   COLOR_W    = 8,
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0,
  parameter int   CHECK_LOG2 = 5,
  parameter int   BAR_W      = 16,
  localparam int  H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HW         = $clog2(H_TOTAL),
  localparam int  VW         = $clog2(V_TOTAL),
  localparam int  PW         = 3 * COLOR_W
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic [PW-1:0] solid_rgb,
  output logic [PW-1:0] vid_data,
  output logic          vid_de,
  output logic          vid_hs,
  output logic          vid_vs,
  output logic          frame_start
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] BAR_LAST = HW'(H_ACTIVE / 8 - 1);
  localparam logic [HW-1:0] OFF_MAX  = HW'(H_ACTIVE - BAR_W);
  localparam logic [31:0]   BAR_W32  = 32'(BAR_W);
  localparam logic [HW-1:0] CHK_HBIT = HW'(1 << CHECK_LOG2);
  localparam logic [VW-1:0] CHK_VBIT = VW'(1 << CHECK_LOG2);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          de, hs, vs, last_pixel;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .en         (en),
    .h          (h),
    .v          (v),
    .de         (de),
    .hs         (hs),
    .vs         (vs),
    .last_pixel (last_pixel)
  );

  // Frame-synchronous state: active mode and moving-bar offset.
  logic [2:0]    act_mode;
  logic [HW-1:0] offset;

  always_ff @(posedge CLK) begin
    if (!RSTn || !en) begin
      act_mode <= MODE_SOLID;
      offset   <= '0;
    end else if (last_pixel) begin
      act_mode <= mode;
      // Advance only while staying in moving-bar mode; entering it restarts at 0.
      if (mode == MODE_MBAR)
        offset <= (act_mode != MODE_MBAR) ? '0 :
                  (offset == OFF_MAX)     ? '0 : offset + HW'(1);
    end
  end

  // Bar index tracks h with a width sub-counter instead of h / (H_ACTIVE/8).
  // It saturates at bar 7, so remainder pixels stay in the last bar.
  logic [HW-1:0] bar_cnt;
  logic [2:0]    bar_idx;

  always_ff @(posedge CLK) begin
    if (!RSTn || !en || h == H_LAST) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (bar_idx != 3'd7) begin
      if (bar_cnt == BAR_LAST) begin
        bar_cnt <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_cnt <= bar_cnt + HW'(1);
      end
    end
  end

  logic [2:0]         mask;
  logic [COLOR_W-1:0] ramp;
  logic               chk_white, in_bar;
  logic [PW-1:0]      pix;

  assign mask      = BAR_MASK[bar_idx];
  assign ramp      = COLOR_W'(h);
  // Squares whose h/v bits agree are white, so (0,0) starts on white.
  assign chk_white = ((|(h & CHK_HBIT)) == (|(v & CHK_VBIT)));
  assign in_bar    = (32'(h) >= 32'(offset)) && (32'(h) < 32'(offset) + BAR_W32);

  always_comb begin
    pix = '0;
    case (act_mode)
      MODE_SOLID: pix = solid_rgb;
      MODE_BARS:  pix = {{COLOR_W{mask[2]}}, {COLOR_W{mask[1]}}, {COLOR_W{mask[0]}}};
      MODE_RAMP:  pix = {3{ramp}};
      MODE_CHECK: pix = chk_white ? '1 : '0;
      MODE_MBAR:  pix = in_bar ? '1 : solid_rgb;
      default:    pix = '0;
    endcase
  end

  // Single output stage: all five outputs move together.
  always_ff @(posedge CLK) begin
    if (!RSTn || !en) begin
      vid_data    <= '0;
      vid_de      <= 1'b0;
      vid_hs      <= ~HS_POL;
      vid_vs      <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      vid_data    <= de ? pix : '0;
      vid_de      <= de;
      vid_hs      <= hs ? HS_POL : ~HS_POL;
      vid_vs      <= vs ? VS_POL : ~VS_POL;
      frame_start <= (h == '0) && (v == '0);
    end
  end

endmodule

// File: tb/tb_video_tpg.sv
// tb_video_tpg: two generators (sync polarity 0 and 1) on a small raster,
// checked every cycle against a position/frame reference model plus
// fixed expectations from the pattern definitions.
module tb_video_tpg;

  localparam int HA = 66, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 36, VFP = 1, VSY = 2, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;   // 82
  localparam int VT = VA + VFP + VSY + VBP;   // 40
  localparam int FR = HT * VT;                // 3280
  localparam int BW = 54;                     // offsets 0..12
  localparam int CK = 5;

  logic        CLK = 1'b0;
  logic        RSTn, en;
  logic [2:0]  mode;
  logic [23:0] solid_rgb;
  logic [23:0] data0, data1;
  logic        de0, hs0, vs0, fs0, de1, hs1, vs1, fs1;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  video_tpg #(
    .COLOR_W(8), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .CHECK_LOG2(CK), .BAR_W(BW)
  ) u_dut0 (
    .CLK(CLK), .RSTn(RSTn), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .vid_data(data0), .vid_de(de0), .vid_hs(hs0), .vid_vs(vs0), .frame_start(fs0)
  );

  video_tpg #(
    .COLOR_W(8), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .CHECK_LOG2(CK), .BAR_W(BW)
  ) u_dut1 (
    .CLK(CLK), .RSTn(RSTn), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .vid_data(data1), .vid_de(de1), .vid_hs(hs1), .vid_vs(vs1), .frame_start(fs1)
  );

  // ---------------- reference model ----------------
  int bar_mask [8] = '{7, 6, 3, 2, 5, 4, 1, 0};

  function automatic logic [23:0] ref_pix(int x, int y, int m, int o, logic [23:0] s);
    int idx;
    logic [2:0] mk;
    logic [7:0] g;
    case (m)
      0: return s;
      1: begin
        idx = x / (HA / 8);
        if (idx > 7) idx = 7;
        mk = 3'(bar_mask[idx]);
        return {{8{mk[2]}}, {8{mk[1]}}, {8{mk[0]}}};
      end
      2: begin g = 8'(x % 256); return {g, g, g}; end
      3: return (((x >> CK) & 1) == ((y >> CK) & 1)) ? 24'hFFFFFF : 24'h0;
      4: return (x >= o && x < o + BW) ? 24'hFFFFFF : s;
      default: return 24'h0;
    endcase
  endfunction

  // Expected outputs for the polarity-0 instance; polarity-1 has hs/vs inverted.
  int          pos = 0, amode = 0, off = 0, mx = 0, my = 0;
  logic [23:0] e_data = '0;
  logic        e_de = 1'b0, e_hs = 1'b1, e_vs = 1'b1, e_fs = 1'b0;

  always @(posedge CLK) begin
    if (!RSTn || !en) begin
      e_data = '0; e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
      pos = 0; amode = 0; off = 0;
    end else begin
      mx = pos % HT;
      my = pos / HT;
      e_de   = (mx < HA) && (my < VA);
      e_hs   = !((mx >= HA + HFP) && (mx < HA + HFP + HSY));
      e_vs   = !((my >= VA + VFP) && (my < VA + VFP + VSY));
      e_fs   = (pos == 0);
      e_data = e_de ? ref_pix(mx, my, amode, off, solid_rgb) : 24'h0;
      if (pos == FR - 1) begin
        pos = 0;
        if (int'(mode) == 4) off = (amode == 4) ? (off + 1) % (HA - BW + 1) : 0;
        amode = int'(mode);
      end else begin
        pos++;
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    RSTn = 1'b0; en = 1'b0; mode = 3'd0; solid_rgb = 24'h123456;
    repeat (3) @(negedge CLK);
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if ({data0, de0, hs0, vs0, fs0} !== {24'h0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
        errors++; $display("FAIL reset_pol0 got %h exp %h", {data0, de0, hs0, vs0, fs0}, {24'h0, 4'b0110});
      end
      checks++;
      if ({data1, de1, hs1, vs1, fs1} !== {24'h0, 4'b0000}) begin
        errors++; $display("FAIL reset_pol1 got %h exp %h", {data1, de1, hs1, vs1, fs1}, {24'h0, 4'b0000});
      end
    end
  endtask

  task automatic test_solid_timing();
    int de_cnt = 0, hs_cnt = 0, hs_first = -1, vs_cnt = 0, vs_first = -1, sol_cnt = 0;
    RSTn = 1'b1;
    for (int i = 0; i < FR; i++) begin
      @(negedge CLK);
      checks++;
      if ({data0, de0, hs0, vs0, fs0} !== {e_data, e_de, e_hs, e_vs, e_fs}) begin
        errors++; $display("FAIL solid_model0 i=%0d got %h exp %h", i, {data0, de0, hs0, vs0, fs0}, {e_data, e_de, e_hs, e_vs, e_fs});
      end
      checks++;
      if ({data1, de1, hs1, vs1, fs1} !== {e_data, e_de, ~e_hs, ~e_vs, e_fs}) begin
        errors++; $display("FAIL solid_model1 i=%0d got %h exp %h", i, {data1, de1, hs1, vs1, fs1}, {e_data, e_de, ~e_hs, ~e_vs, e_fs});
      end
      if (i == 0) begin
        checks++;
        if (fs0 !== 1'b1) begin errors++; $display("FAIL first_frame_start got %b exp 1", fs0); end
      end
      if (i < HT && de0) de_cnt++;
      if (i < HT && !hs0) begin hs_cnt++; if (hs_first < 0) hs_first = i; end
      if (!vs0) begin vs_cnt++; if (vs_first < 0) vs_first = i; end
      if (de0 && data0 == 24'h123456) sol_cnt++;
      if (i == 700) mode = 3'd1;  // takes effect at next frame only
    end
    checks++; if (de_cnt != HA) begin errors++; $display("FAIL de_per_line got %0d exp %0d", de_cnt, HA); end
    checks++; if (hs_cnt != HSY) begin errors++; $display("FAIL hs_width got %0d exp %0d", hs_cnt, HSY); end
    checks++; if (hs_first != HA + HFP) begin errors++; $display("FAIL hs_start got %0d exp %0d", hs_first, HA + HFP); end
    checks++; if (vs_cnt != VSY * HT) begin errors++; $display("FAIL vs_width got %0d exp %0d", vs_cnt, VSY * HT); end
    checks++; if (vs_first != (VA + VFP) * HT) begin errors++; $display("FAIL vs_start got %0d exp %0d", vs_first, (VA + VFP) * HT); end
    checks++; if (sol_cnt != HA * VA) begin errors++; $display("FAIL solid_pixels got %0d exp %0d", sol_cnt, HA * VA); end
  endtask

  // Bars frame; a mid-frame switch to checkerboard must wait for the next frame.
  task automatic test_mode_switch();
    int          px [6]  = '{0, 8, 31, 40, 63, 65};
    logic [23:0] ex [6]  = '{24'hFFFFFF, 24'hFFFF00, 24'h00FF00, 24'hFF0000, 24'h000000, 24'h000000};
    for (int i = 0; i < FR; i++) begin
      @(negedge CLK);
      checks++;
      if ({data0, de0, hs0, vs0, fs0} !== {e_data, e_de, e_hs, e_vs, e_fs}) begin
        errors++; $display("FAIL bars_model0 i=%0d got %h exp %h", i, {data0, de0, hs0, vs0, fs0}, {e_data, e_de, e_hs, e_vs, e_fs});
      end
      checks++;
      if ({data1, de1, hs1, vs1, fs1} !== {e_data, e_de, ~e_hs, ~e_vs, e_fs}) begin
        errors++; $display("FAIL bars_model1 i=%0d got %h exp %h", i, {data1, de1, hs1, vs1, fs1}, {e_data, e_de, ~e_hs, ~e_vs, e_fs});
      end
      for (int k = 0; k < 6; k++) if (i == px[k]) begin
        checks++;
        if (data0 !== ex[k]) begin errors++; $display("FAIL bar_pixel x=%0d got %h exp %h", i, data0, ex[k]); end
      end
      if (i == 1500) mode = 3'd3;
    end
  endtask

  task automatic test_check();
    int          px [5] = '{0, 8, 32, 32 * HT, 32 * HT + 32};
    logic [23:0] ex [5] = '{24'hFFFFFF, 24'hFFFFFF, 24'h0, 24'h0, 24'hFFFFFF};
    for (int i = 0; i < FR; i++) begin
      @(negedge CLK);
      checks++;
      if ({data0, de0, hs0, vs0, fs0} !== {e_data, e_de, e_hs, e_vs, e_fs}) begin
        errors++; $display("FAIL check_model0 i=%0d got %h exp %h", i, {data0, de0, hs0, vs0, fs0}, {e_data, e_de, e_hs, e_vs, e_fs});
      end
      checks++;
      if ({data1, de1, hs1, vs1, fs1} !== {e_data, e_de, ~e_hs, ~e_vs, e_fs}) begin
        errors++; $display("FAIL check_model1 i=%0d got %h exp %h", i, {data1, de1, hs1, vs1, fs1}, {e_data, e_de, ~e_hs, ~e_vs, e_fs});
      end
      for (int k = 0; k < 5; k++) if (i == px[k]) begin
        checks++;
        if (data0 !== ex[k] || (k == 0 && fs0 !== 1'b1)) begin
          errors++; $display("FAIL check_pixel pos=%0d got %h fs=%b exp %h", i, data0, fs0, ex[k]);
        end
      end
      if (i == 1500) begin mode = 3'd2; solid_rgb = 24'($urandom) & 24'h7F7F7F; end
    end
  endtask

  task automatic test_ramp();
    for (int i = 0; i < FR; i++) begin
      @(negedge CLK);
      checks++;
      if ({data0, de0, hs0, vs0, fs0} !== {e_data, e_de, e_hs, e_vs, e_fs}) begin
        errors++; $display("FAIL ramp_model0 i=%0d got %h exp %h", i, {data0, de0, hs0, vs0, fs0}, {e_data, e_de, e_hs, e_vs, e_fs});
      end
      if (i == 44 || i == HT + 65) begin
        checks++;
        if (data0 !== ((i == 44) ? 24'h2C2C2C : 24'h414141)) begin
          errors++; $display("FAIL ramp_pixel pos=%0d got %h", i, data0);
        end
      end
      if (i == 1200) mode = 3'd4;
    end
  endtask

  task automatic test_mbar();
    for (int f = 0; f < 14; f++) begin
      for (int i = 0; i < FR; i++) begin
        @(negedge CLK);
        checks++;
        if ({data0, de0, hs0, vs0, fs0} !== {e_data, e_de, e_hs, e_vs, e_fs}) begin
          errors++; $display("FAIL mbar_model0 f=%0d i=%0d got %h exp %h", f, i, {data0, de0, hs0, vs0, fs0}, {e_data, e_de, e_hs, e_vs, e_fs});
        end
        checks++;
        if ({data1, de1, hs1, vs1, fs1} !== {e_data, e_de, ~e_hs, ~e_vs, e_fs}) begin
          errors++; $display("FAIL mbar_model1 f=%0d i=%0d got %h exp %h", f, i, {data1, de1, hs1, vs1, fs1}, {e_data, e_de, ~e_hs, ~e_vs, e_fs});
        end
        // bar edges: frame 0 at 0..53, frame 3 at 3..56, frame 13 wrapped to 0..53
        if ((f == 0 || f == 13) && (i == 0 || i == 53 || i == 54) ||
            (f == 3) && (i == 2 || i == 3 || i == 56 || i == 57)) begin
          checks++;
          if (data0 !== (((f == 3) ? (i >= 3 && i <= 56) : (i <= 53)) ? 24'hFFFFFF : solid_rgb)) begin
            errors++; $display("FAIL mbar_edge f=%0d x=%0d got %h bg %h", f, i, data0, solid_rgb);
          end
        end
        if (i == 2000) solid_rgb = 24'($urandom) & 24'h7F7F7F;
        if (f == 13 && i == 1500) mode = 3'(5 + $urandom_range(0, 2));
      end
    end
  endtask

  task automatic test_black();
    for (int i = 0; i < FR; i++) begin
      @(negedge CLK);
      checks++;
      if ({data0, de0, hs0, vs0, fs0} !== {e_data, e_de, e_hs, e_vs, e_fs}) begin
        errors++; $display("FAIL black_model0 i=%0d got %h exp %h", i, {data0, de0, hs0, vs0, fs0}, {e_data, e_de, e_hs, e_vs, e_fs});
      end
      if (i == 0) begin
        checks++;
        if ({data0, de0, fs0} !== {24'h0, 2'b11}) begin
          errors++; $display("FAIL black_pixel got %h de=%b fs=%b exp 000000 1 1", data0, de0, fs0);
        end
      end
      if (i == 1500) mode = 3'd0;
    end
  endtask

  task automatic test_reset_mid();
    int n = int'($urandom_range(10, 70));
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      checks++;
      if ({data0, de0, hs0, vs0, fs0} !== {e_data, e_de, e_hs, e_vs, e_fs}) begin
        errors++; $display("FAIL rmid_model0 i=%0d got %h exp %h", i, {data0, de0, hs0, vs0, fs0}, {e_data, e_de, e_hs, e_vs, e_fs});
      end
    end
    mode = 3'd3;  // must not apply to the restarted frame
    RSTn = 1'b0;
    @(negedge CLK);
    checks++;
    if ({data0, de0, hs0, vs0, fs0, hs1, vs1} !== {24'h0, 6'b011000}) begin
      errors++; $display("FAIL rmid_reset got %h exp %h", {data0, de0, hs0, vs0, fs0, hs1, vs1}, {24'h0, 6'b011000});
    end
    RSTn = 1'b1;
    @(negedge CLK);
    checks++;
    if ({data0, de0, fs0} !== {solid_rgb, 2'b11}) begin
      errors++; $display("FAIL rmid_restart got %h de=%b fs=%b exp %h 1 1", data0, de0, fs0, solid_rgb);
    end
    for (int i = 1; i < 200; i++) begin
      @(negedge CLK);
      checks++;
      if ({data0, de0, hs0, vs0, fs0} !== {e_data, e_de, e_hs, e_vs, e_fs}) begin
        errors++; $display("FAIL rmid_after0 i=%0d got %h exp %h", i, {data0, de0, hs0, vs0, fs0}, {e_data, e_de, e_hs, e_vs, e_fs});
      end
    end
  endtask

  task automatic test_en_low();
    mode = 3'd0;
    en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      checks++;
      if ({data0, de0, hs0, vs0, fs0, data1, de1, hs1, vs1, fs1} !== {24'h0, 4'b0110, 24'h0, 4'b0000}) begin
        errors++; $display("FAIL en_low i=%0d got %h/%h", i, {data0, de0, hs0, vs0, fs0}, {data1, de1, hs1, vs1, fs1});
      end
    end
    en = 1'b1;
    @(negedge CLK);
    checks++;
    if ({data0, de0, fs0} !== {solid_rgb, 2'b11}) begin
      errors++; $display("FAIL en_restart got %h de=%b fs=%b exp %h 1 1", data0, de0, fs0, solid_rgb);
    end
    // Run to the last pixel, dropping en on the same edge as the frame boundary.
    for (int i = 1; i <= FR - 2; i++) begin
      @(negedge CLK);
      checks++;
      if ({data0, de0, hs0, vs0, fs0} !== {e_data, e_de, e_hs, e_vs, e_fs}) begin
        errors++; $display("FAIL en_frame_model0 i=%0d got %h exp %h", i, {data0, de0, hs0, vs0, fs0}, {e_data, e_de, e_hs, e_vs, e_fs});
      end
      if (i == FR - 2) begin en = 1'b0; mode = 3'd4; end
    end
    @(negedge CLK);
    checks++;
    if ({data0, de0, hs0, vs0, fs0} !== {24'h0, 4'b0110}) begin
      errors++; $display("FAIL en_vs_boundary got %h exp %h", {data0, de0, hs0, vs0, fs0}, {24'h0, 4'b0110});
    end
    en = 1'b1;
    @(negedge CLK);
    checks++;
    if ({data0, de0, fs0} !== {solid_rgb, 2'b11}) begin
      errors++; $display("FAIL en_boundary_mode got %h fs=%b exp %h (mode held at solid)", data0, fs0, solid_rgb);
    end
    for (int i = 1; i < 100; i++) begin
      @(negedge CLK);
      checks++;
      if ({data1, de1, hs1, vs1, fs1} !== {e_data, e_de, ~e_hs, ~e_vs, e_fs}) begin
        errors++; $display("FAIL en_after1 i=%0d got %h exp %h", i, {data1, de1, hs1, vs1, fs1}, {e_data, e_de, ~e_hs, ~e_vs, e_fs});
      end
    end
  endtask

  initial begin
    RSTn = 1'b0; en = 1'b0; mode = 3'd0; solid_rgb = '0;
    test_reset();
    test_solid_timing();
    test_mode_switch();
    test_check();
    test_ramp();
    test_mbar();
    test_black();
    test_reset_mid();
    test_en_low();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
